// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one ready-handshaked imem fetch at a time and
// registers {instr, pc, ctrl} for IF/ID. Optional stall/wait counter under IF_PERF_CNT_EN.
module instr_fetch_unit #(
   parameter int         S        = 15,
   parameter int         C        = 1,
   parameter logic [S:0] RESET_PC = '0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       redirect_en,
   input  logic [S:0] redirect_pc,
   output logic       imem_req,
   output logic [S:0] imem_addr,
   input  logic       imem_ready,
   input  logic [S:0] imem_rdata,
   output logic [S:0] out_instr,
   output logic [S:0] out_pc,
   output logic [C:0] out_ctrl
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   localparam logic [C:0] CTRL_NONE  = '0;
   localparam logic [C:0] CTRL_VALID = (C+1)'(1);
   localparam logic [C:0] CTRL_FLUSH = (C+1)'(2);

   state_t     state_q, state_d;
   logic [S:0] pc_q, pc_d;
   logic [S:0] instr_q, instr_d;
   logic [S:0] opc_q, opc_d;
   logic [C:0] ctrl_q, ctrl_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         opc_q   <= '0;
         ctrl_q  <= CTRL_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Redirect wins over everything, including stall and any response arriving that cycle.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      opc_d     = opc_q;
      ctrl_d    = ctrl_q;
      imem_req  = (state_q == FETCH);
      imem_addr = pc_q;
      if (redirect_en) begin
         pc_d    = {redirect_pc[S:1], 1'b0};
         instr_d = '0;
         ctrl_d  = CTRL_FLUSH;
         state_d = FETCH;
      end else begin
         case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (imem_ready && !stall) begin
                  instr_d = imem_rdata;
                  opc_d   = pc_q;
                  ctrl_d  = CTRL_VALID;
                  pc_d    = pc_q + (S+1)'(2);
               end else if (imem_ready && stall) begin
                  // Response dropped; the same address is refetched once the stall clears.
                  state_d = HOLD;
               end else if (!imem_ready && !stall) begin
                  instr_d = '0;
                  ctrl_d  = CTRL_NONE;
               end
            end
            HOLD: begin
               if (!stall) state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign out_instr = instr_q;
   assign out_pc    = opc_q;
   assign out_ctrl  = ctrl_q;

`ifdef IF_PERF_CNT_EN
   logic [15:0] perf_cnt_q, perf_cnt_d;
   logic        perf_inc;

   always_comb begin
      perf_inc   = ((state_q == FETCH) && !imem_ready) || (state_q == HOLD) || stall;
      perf_cnt_d = perf_cnt_q;
      if (perf_inc && (perf_cnt_q != 16'hFFFF)) perf_cnt_d = perf_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_cnt_q <= '0;
      else      perf_cnt_q <= perf_cnt_d;
   end

   assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for fetch/bubble/stall/redirect/wrap,
// plus hand sequences for async reset mid-fetch and the optional stall counter.
module tb_instr_fetch_unit;

   localparam logic [15:0] K = 16'hC3A5;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect_en, imem_ready;
   logic [15:0] redirect_pc;
   logic        imem_req, imem_req2;
   logic [15:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
   logic [15:0] out_instr, out_pc, out_instr2, out_pc2;
   logic [1:0]  out_ctrl, out_ctrl2;
`ifdef IF_PERF_CNT_EN
   logic [15:0] perf_stall_cnt, perf_stall_cnt2;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_rdata  = imem_addr ^ K;
   assign imem_rdata2 = imem_addr2 ^ K;

   instr_fetch_unit #(.S(15), .C(1), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl)
`ifdef IF_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   instr_fetch_unit #(.S(15), .C(1), .RESET_PC(16'hFFFE)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata2),
      .out_instr(out_instr2), .out_pc(out_pc2), .out_ctrl(out_ctrl2)
`ifdef IF_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt2)
`endif
   );

   typedef struct {
      logic        stall;
      logic        ready;
      logic        redir;
      logic [15:0] rpc;
      logic [15:0] e_instr;
      logic [15:0] e_pc;
      logic [1:0]  e_ctrl;
      logic        e_req;
      logic [15:0] e_addr;
      logic        chk2;
      logic [15:0] e_pc2;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            stall ready redir rpc       instr          pc        ctrl   req addr      chk2 pc2
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000,      16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, 16'h0000};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000 ^ K,  16'h0000, 2'b01, 1'b1, 16'h0002, 1'b1, 16'hFFFE};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002 ^ K,  16'h0002, 2'b01, 1'b1, 16'h0004, 1'b1, 16'h0000};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000,      16'h0002, 2'b00, 1'b1, 16'h0004, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000,      16'h0002, 2'b00, 1'b1, 16'h0004, 1'b0, 16'h0000};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004 ^ K,  16'h0004, 2'b01, 1'b1, 16'h0006, 1'b0, 16'h0000};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006 ^ K,  16'h0006, 2'b01, 1'b1, 16'h0008, 1'b0, 16'h0000};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0006 ^ K,  16'h0006, 2'b01, 1'b0, 16'h0008, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0006 ^ K,  16'h0006, 2'b01, 1'b0, 16'h0008, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0006 ^ K,  16'h0006, 2'b01, 1'b0, 16'h0008, 1'b0, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006 ^ K,  16'h0006, 2'b01, 1'b1, 16'h0008, 1'b0, 16'h0000};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0101, 16'h0000,      16'h0006, 2'b10, 1'b1, 16'h0100, 1'b0, 16'h0000};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100 ^ K,  16'h0100, 2'b01, 1'b1, 16'h0102, 1'b0, 16'h0000};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0200, 16'h0000,      16'h0100, 2'b10, 1'b1, 16'h0200, 1'b0, 16'h0000};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,      16'h0100, 2'b10, 1'b1, 16'h0200, 1'b0, 16'h0000};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200 ^ K,  16'h0200, 2'b01, 1'b1, 16'h0202, 1'b0, 16'h0000};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000,      16'h0200, 2'b10, 1'b1, 16'hFFFE, 1'b0, 16'h0000};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE ^ K,  16'hFFFE, 2'b01, 1'b1, 16'h0000, 1'b0, 16'h0000};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000 ^ K,  16'h0000, 2'b01, 1'b1, 16'h0002, 1'b0, 16'h0000};

      rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
      step(); step();
      chk("rst_instr", out_instr, 16'h0000);
      chk("rst_pc", out_pc, 16'h0000);
      chk("rst_ctrl", {14'd0, out_ctrl}, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'h0000);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_addr2", imem_addr2, 16'hFFFE);
      rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         stall       = vecs[i].stall;
         imem_ready  = vecs[i].ready;
         redirect_en = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         step();
         chk($sformatf("v%0d_instr", i), out_instr, vecs[i].e_instr);
         chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_ctrl", i), {14'd0, out_ctrl}, {14'd0, vecs[i].e_ctrl});
         chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         if (vecs[i].chk2) chk($sformatf("v%0d_pc2", i), out_pc2, vecs[i].e_pc2);
      end

      // Async reset while a fetch is outstanding
      stall = 1'b0; redirect_en = 1'b0; imem_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_req", {15'd0, imem_req}, 16'h0000);
      chk("arst_pc", out_pc, 16'h0000);
      chk("arst_instr", out_instr, 16'h0000);
      step();
      rst = 1'b1;

      // 5 stalled wait cycles then 2 plain wait cycles
      step();
      chk("wait_req", {15'd0, imem_req}, 16'h0001);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) step();
      stall = 1'b0;
      for (int i = 0; i < 2; i++) step();
      chk("wait_ctrl", {14'd0, out_ctrl}, 16'h0000);
      chk("wait_req2", {15'd0, imem_req}, 16'h0001);
`ifdef IF_PERF_CNT_EN
      chk("perf_cnt7", perf_stall_cnt, 16'd7);
`endif
      #2 rst = 1'b0;
      #1;
      chk("arst2_req", {15'd0, imem_req}, 16'h0000);
`ifdef IF_PERF_CNT_EN
      chk("perf_cnt_rst", perf_stall_cnt, 16'd0);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
